// File: rtl/out_display_if.sv
// out_display_if: OUT-register capture strobe/value in, 7-segment scan drive and busy out.
`default_nettype none

interface out_display_if;
  logic [7:0] value;
  logic       load;
  logic [6:0] seg;
  logic [3:0] digit;
  logic       busy;

  modport master (output value, load, input seg, digit, busy);
  modport slave  (input value, load, output seg, digit, busy);
endinterface

`default_nettype wire

// File: rtl/out_display.sv
// out_display: SAP-1 OUT register to 4-digit multiplexed 7-segment driver (sequential double-dabble).
// Optional macro OUT_DISPLAY_SIGNED_EN: treat value as two's complement and show a minus sign on digit 3.
`default_nettype none

module out_display #(
  parameter int MUX_DIV = 1024
) (
  input  logic         clk,
  input  logic         reset,
  out_display_if.slave bus
);

  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_CONV   = 1'b1;
  localparam logic [15:0] DIV_LAST = 16'(MUX_DIV - 1);

  logic [0:0]  state;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [2:0]  step;
  logic        sign_pend;
  logic        busy_q;

  logic [3:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic        sign;

  logic [15:0] div;
  logic [1:0]  idx;

  logic [7:0]  mag;
  logic        neg;
  logic [11:0] bcd_adj;
  logic [19:0] shifted;

`ifdef OUT_DISPLAY_SIGNED_EN
  assign neg = bus.value[7];
  assign mag = neg ? 8'(~bus.value + 8'd1) : bus.value;
`else
  assign neg = 1'b0;
  assign mag = bus.value;
`endif

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
  endfunction

  assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign shifted = {bcd_adj, bin} << 1;

  // A load on the final step still commits the old result, then restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bin       <= '0;
      bcd       <= '0;
      step      <= '0;
      sign_pend <= 1'b0;
      busy_q    <= 1'b0;
      hund      <= '0;
      tens      <= '0;
      ones      <= '0;
      sign      <= 1'b0;
    end else begin
      if (state == S_CONV) begin
        bcd  <= shifted[19:8];
        bin  <= shifted[7:0];
        step <= step + 3'd1;
        if (step == 3'd7) begin
          hund   <= shifted[19:16];
          tens   <= shifted[15:12];
          ones   <= shifted[11:8];
          sign   <= sign_pend;
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      end
      if (bus.load) begin
        bin       <= mag;
        bcd       <= '0;
        step      <= '0;
        sign_pend <= neg;
        state     <= S_CONV;
        busy_q    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 16'd1;
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [3:0] cur;
  logic       blank;
  logic       minus;

  always_comb begin
    cur   = ones;
    blank = 1'b0;
    minus = 1'b0;
    case (idx)
      2'd0: cur = ones;
      2'd1: begin
        cur   = tens;
        blank = (hund == 4'd0) && (tens == 4'd0);
      end
      2'd2: begin
        cur   = hund;
        blank = (hund == 4'd0);
      end
      default: begin
        blank = !sign;
        minus = sign;
      end
    endcase
  end

  assign bus.seg   = blank ? 7'h00 : (minus ? 7'h40 : enc(cur));
  assign bus.digit = 4'b0001 << idx;
  assign bus.busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_out_display.sv
// tb_out_display: directed scoreboard bench for out_display with a short scan period.
`default_nettype none

module tb_out_display;

  localparam int MUX_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  out_display_if bus ();

  out_display #(.MUX_DIV(MUX_DIV)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [27:0] exp_q[$];
  int cyc;
  bit scan_chk = 0;
  bit watch7   = 0;
  bit seen7    = 0;

  // Reference scan position: counts clock edges since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_chk && rst_n) begin
      n_tests++;
      assert (bus.digit === 4'(32'd1 << ((cyc / MUX_DIV) % 4))) else begin
        n_fail++;
        $error("FAIL scan: observed digit=%b expected %b at cyc %0d",
               bus.digit, 4'(32'd1 << ((cyc / MUX_DIV) % 4)), cyc);
      end
      if (watch7 && bus.digit == 4'b0001 && bus.seg == 7'h07) seen7 = 1;
    end
  end

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  // Expected {digit3, digit2, digit1, digit0} segment patterns for a value.
  function automatic logic [27:0] model(input logic [7:0] v);
    int m, h, t, o;
    bit neg;
    logic [6:0] d0, d1, d2, d3;
    neg = 0;
    m = int'(v);
`ifdef OUT_DISPLAY_SIGNED_EN
    if (v[7]) begin
      neg = 1;
      m = 256 - int'(v);
    end
`endif
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    d0 = enc(o);
    d1 = (h == 0 && t == 0) ? 7'h00 : enc(t);
    d2 = (h == 0) ? 7'h00 : enc(h);
    d3 = neg ? 7'h40 : 7'h00;
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: present value with load high for one edge.
  task automatic drive(input logic [7:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(model(v));
    @(negedge clk);
  endtask

  task automatic read_disp(output logic [27:0] d);
    logic [27:0] tmp;
    tmp = 'x;
    for (int i = 0; i < 4 * MUX_DIV; i++) begin
      @(negedge clk);
      case (bus.digit)
        4'b0001: tmp[6:0]   = bus.seg;
        4'b0010: tmp[13:7]  = bus.seg;
        4'b0100: tmp[20:14] = bus.seg;
        4'b1000: tmp[27:21] = bus.seg;
        default: tmp = 'x;
      endcase
    end
    d = tmp;
  endtask

  // Counts negedges with busy high, then pops and compares the committed display.
  task automatic wait_commit(input string tag);
    int n;
    logic [27:0] got;
    logic [27:0] exp;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd8);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    read_disp(got);
    check({tag, "_display"}, {4'h0, got}, {4'h0, exp});
  endtask

  initial begin
    logic [27:0] got;
    bus.value = 8'h00;
    bus.load  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_digit", 32'(bus.digit), 32'h1);
    check("rst_seg",   32'(bus.seg),   32'h3F);
    check("rst_busy",  32'(bus.busy),  32'h0);
    rst_n = 1'b1;
    scan_chk = 1;
    repeat (4) @(negedge clk);
    check("scan_digit1", 32'(bus.digit), 32'h2);
    check("scan_blank_tens", 32'(bus.seg), 32'h00);

    drive(8'h00);
    bus.load = 1'b0;
    wait_commit("v00");

    drive(8'h80);
    bus.load = 1'b0;
    wait_commit("v80");

    drive(8'hF5);
    bus.load = 1'b0;
    wait_commit("vF5");

    // Latest load wins; the intermediate 7 must never reach the display.
    seen7 = 0;
    watch7 = 1;
    drive(8'h07);
    bus.load = 1'b0;
    check("restart_busy_a", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("restart_busy_b", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("restart_busy_c", 32'(bus.busy), 32'h1);
    drive(8'h64);
    bus.load = 1'b0;
    wait_commit("v64");
    watch7 = 0;
    check("never_seven", 32'(seen7), 32'h0);

    // Reset in the middle of a conversion.
    drive(8'hFF);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_digit", 32'(bus.digit), 32'h1);
    check("midrst_seg",   32'(bus.seg),   32'h3F);
    check("midrst_busy",  32'(bus.busy),  32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    read_disp(got);
    check("postrst_display", {4'h0, got}, {4'h0, model(8'h00)});
    check("postrst_busy", 32'(bus.busy), 32'h0);

    // Load on every edge; busy must hold and only the last value commits.
    for (int i = 0; i < 19; i++) begin
      drive(8'(8'h10 + i * 7));
      if (i > 0) check("b2b_busy", 32'(bus.busy), 32'h1);
    end
    drive(8'h2A);
    bus.load = 1'b0;
    wait_commit("v2A");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
